// File: rtl/mips_write_buffer.sv
// Posted-write buffer between a CPU-side Avalon slave and an Avalon master; reads wait for the buffer to drain.
// Optional macro MIPS_WB_COALESCE_EN merges a write into the newest entry when the addresses match.
module mips_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       cpu_address,
    input  logic                    cpu_write,
    input  logic                    cpu_read,
    input  logic [DATA_W-1:0]       cpu_writedata,
    input  logic [DATA_W/8-1:0]     cpu_byteenable,
    output logic                    cpu_waitrequest,
    output logic [DATA_W-1:0]       cpu_readdata,
    output logic [ADDR_W-1:0]       mem_address,
    output logic                    mem_write,
    output logic                    mem_read,
    output logic [DATA_W-1:0]       mem_writedata,
    output logic [DATA_W/8-1:0]     mem_byteenable,
    input  logic                    mem_waitrequest,
    input  logic [DATA_W-1:0]       mem_readdata,
    output logic                    wb_empty,
    output logic [$clog2(DEPTH):0]  wb_count
);
    localparam int BE_W = DATA_W / 8;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_DONE} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [BE_W-1:0]   be_q   [DEPTH];
    logic [BE_W-1:0]   be_d   [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [PW-1:0]     newest;
    logic              merge, wr_acc, push, pop;

    always_comb begin
        newest = tail_q - PW'(1);
`ifdef MIPS_WB_COALESCE_EN
        // The head being presented on the bus must stay stable, so it is never a merge target.
        merge = cpu_write && (count_q != '0) && (addr_q[newest] == cpu_address)
                && !((state_q == WR_ISSUE) && (newest == head_q));
`else
        merge = 1'b0;
`endif
        wr_acc = cpu_write && ((count_q != FULL) || merge);
        push   = wr_acc && !merge;
        pop    = (state_q == WR_ISSUE) && !mem_waitrequest;

        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);

        addr_d = addr_q;
        data_d = data_q;
        be_d   = be_q;
        if (push) begin
            addr_d[tail_q] = cpu_address;
            data_d[tail_q] = cpu_writedata;
            be_d[tail_q]   = cpu_byteenable;
        end else if (merge) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (cpu_byteenable[i]) data_d[newest][8*i +: 8] = cpu_writedata[8*i +: 8];
            end
            be_d[newest] = be_q[newest] | cpu_byteenable;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0)                state_d = WR_ISSUE;
                else if (cpu_read && !cpu_write)  state_d = RD_ISSUE;
            end
            WR_ISSUE: begin
                if (pop && (count_d == '0)) state_d = IDLE;
            end
            RD_ISSUE: begin
                if (!mem_waitrequest) begin
                    rdata_d = mem_readdata;
                    state_d = RD_DONE;
                end
            end
            RD_DONE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_write      = (state_q == WR_ISSUE);
        mem_read       = (state_q == RD_ISSUE);
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        if (state_q == WR_ISSUE) begin
            mem_address    = addr_q[head_q];
            mem_writedata  = data_q[head_q];
            mem_byteenable = be_q[head_q];
        end else if (state_q == RD_ISSUE) begin
            mem_address    = cpu_address;
            mem_byteenable = cpu_byteenable;
        end
        // A simultaneous read+write is handled purely as a write.
        if (reset)          cpu_waitrequest = 1'b1;
        else if (cpu_write) cpu_waitrequest = !wr_acc;
        else                cpu_waitrequest = (state_q != RD_DONE);
        cpu_readdata = rdata_q;
        wb_count     = count_q;
        wb_empty     = (count_q == '0) && (state_q != WR_ISSUE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            addr_q  <= '{default: '0};
            data_q  <= '{default: '0};
            be_q    <= '{default: '0};
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mips_write_buffer.sv
// Self-checking bench for mips_write_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_mips_write_buffer;
    localparam int DEPTH = 4;

`ifdef MIPS_WB_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_address, cpu_writedata, cpu_readdata;
    logic        cpu_write, cpu_read, cpu_waitrequest;
    logic [3:0]  cpu_byteenable, mem_byteenable;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_write, mem_read, mem_waitrequest;
    logic        wb_empty;
    logic [2:0]  wb_count;

    int total = 0;
    int bad   = 0;

    mips_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_read(cpu_read),
        .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
        .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
        .mem_address(mem_address), .mem_write(mem_write), .mem_read(mem_read),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .wb_empty(wb_empty), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_write = 1'b0; cpu_read = 1'b0; cpu_address = '0;
        cpu_writedata = '0; cpu_byteenable = '0; mem_waitrequest = 1'b0; mem_readdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_wait got=%b exp=1", cpu_waitrequest); end
        total++; if (wb_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", wb_count); end
        total++; if ({mem_write, mem_read, wb_empty} !== 3'b001) begin bad++; $display("FAIL reset_flags got=%b exp=001", {mem_write, mem_read, wb_empty}); end
        total++; if ({mem_address, mem_writedata, mem_byteenable, cpu_readdata} !== '0) begin bad++; $display("FAIL reset_buses got=%h %h %h %h exp=0", mem_address, mem_writedata, mem_byteenable, cpu_readdata); end
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_fill_order();
        logic [31:0] addrs [5];
        addrs = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
        mem_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            cpu_write = 1'b1; cpu_address = addrs[i]; cpu_writedata = $urandom; cpu_byteenable = 4'hF;
            @(negedge clk);
            total++; if (cpu_waitrequest !== (i == 4)) begin bad++; $display("FAIL fill_wait[%0d] got=%b exp=%b", i, cpu_waitrequest, (i == 4)); end
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            mem_waitrequest = (i < 2);
            @(negedge clk);
            total++; if (cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL full_stall[%0d] got=%b exp=1", i, cpu_waitrequest); end
            total++; if (!mem_write || mem_address !== 32'h10) begin bad++; $display("FAIL head_addr[%0d] got=%b/%h exp=1/10", i, mem_write, mem_address); end
        end
        cyc();
        @(negedge clk);
        total++; if (cpu_waitrequest !== 1'b0) begin bad++; $display("FAIL fifth_accept got=%b exp=0", cpu_waitrequest); end
        total++; if (!mem_write || mem_address !== 32'h14) begin bad++; $display("FAIL order_14 got=%b/%h exp=1/14", mem_write, mem_address); end
        for (int i = 2; i < 5; i++) begin
            cyc();
            cpu_write = 1'b0;
            @(negedge clk);
            total++; if (!mem_write || mem_address !== addrs[i]) begin bad++; $display("FAIL order[%0d] got=%b/%h exp=1/%h", i, mem_write, mem_address, addrs[i]); end
        end
        cyc();
        @(negedge clk);
        total++; if (wb_empty !== 1'b1 || wb_count !== 3'd0) begin bad++; $display("FAIL fill_drained got=%b/%0d exp=1/0", wb_empty, wb_count); end
    endtask

    task automatic test_read_after_write();
        logic [31:0] rd;
        bit saw_w, done;
        cyc();
        cpu_write = 1'b1; cpu_address = 32'h40; cpu_writedata = 32'hAABBCCDD; cpu_byteenable = 4'hF; mem_waitrequest = 1'b1;
        @(negedge clk);
        total++; if (cpu_waitrequest !== 1'b0) begin bad++; $display("FAIL raw_wr_accept got=%b exp=0", cpu_waitrequest); end
        saw_w = 1'b0; done = 1'b0; rd = 'x;
        for (int c = 0; c < 30 && !done; c++) begin
            cyc();
            cpu_write = 1'b0; cpu_read = 1'b1; cpu_address = 32'h40; mem_waitrequest = (c < 3); mem_readdata = $urandom;
            @(negedge clk);
            total++; if (mem_write && mem_read) begin bad++; $display("FAIL raw_exclusive got=11 exp=not both"); end
            if (mem_write && !mem_waitrequest) begin
                total++; if ({mem_address, mem_writedata, mem_byteenable} !== {32'h40, 32'hAABBCCDD, 4'hF}) begin bad++; $display("FAIL raw_memwr got=%h/%h/%h exp=40/aabbccdd/f", mem_address, mem_writedata, mem_byteenable); end
                saw_w = 1'b1;
            end
            if (mem_read) begin
                total++; if (!saw_w || mem_address !== 32'h40) begin bad++; $display("FAIL raw_rd_order got=%b/%h exp=1/40", saw_w, mem_address); end
                if (!mem_waitrequest) rd = mem_readdata;
            end
            if (!cpu_waitrequest) begin
                total++; if (!saw_w || cpu_readdata !== rd) begin bad++; $display("FAIL raw_rdata got=%h exp=%h", cpu_readdata, rd); end
                done = 1'b1;
            end
        end
        total++; if (!done) begin bad++; $display("FAIL raw_timeout got=pending exp=done"); end
        cyc();
        cpu_read = 1'b0;
    endtask

    task automatic test_read_latency();
        logic [31:0] rv;
        rv = $urandom;
        cyc();
        cpu_read = 1'b1; cpu_address = 32'h100; cpu_byteenable = 4'hF; mem_waitrequest = 1'b0; mem_readdata = rv;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (cpu_waitrequest !== (c < 2)) begin bad++; $display("FAIL lat_wait[%0d] got=%b exp=%b", c, cpu_waitrequest, (c < 2)); end
            if (c < 2) cyc();
        end
        total++; if (cpu_readdata !== rv) begin bad++; $display("FAIL lat_rdata got=%h exp=%h", cpu_readdata, rv); end
        cyc();
        cpu_read = 1'b0;
    endtask

    task automatic test_coalesce();
        ent_t exp_q[$];
        int exp_cnt;
        mem_waitrequest = 1'b1;
        cyc();
        cpu_write = 1'b1; cpu_address = 32'h70; cpu_writedata = 32'h12345678; cpu_byteenable = 4'hF;
        cyc();
        cpu_write = 1'b0;
        cyc();
        cpu_write = 1'b1; cpu_address = 32'h80; cpu_writedata = 32'h00001122; cpu_byteenable = 4'b0011;
        @(negedge clk);
        total++; if (cpu_waitrequest !== 1'b0) begin bad++; $display("FAIL coal_w1 got=%b exp=0", cpu_waitrequest); end
        cyc();
        cpu_writedata = 32'h33440000; cpu_byteenable = 4'b1100;
        @(negedge clk);
        total++; if (cpu_waitrequest !== 1'b0) begin bad++; $display("FAIL coal_w2 got=%b exp=0", cpu_waitrequest); end
        cyc();
        cpu_write = 1'b0;
        exp_cnt = COAL ? 2 : 3;
        @(negedge clk);
        total++; if (wb_count !== 3'(exp_cnt)) begin bad++; $display("FAIL coal_count got=%0d exp=%0d", wb_count, exp_cnt); end
        exp_q.push_back('{a: 32'h70, d: 32'h12345678, b: 4'hF});
        if (COAL) exp_q.push_back('{a: 32'h80, d: 32'h33441122, b: 4'hF});
        else begin
            exp_q.push_back('{a: 32'h80, d: 32'h00001122, b: 4'h3});
            exp_q.push_back('{a: 32'h80, d: 32'h33440000, b: 4'hC});
        end
        for (int c = 0; c < 20; c++) begin
            cyc();
            mem_waitrequest = 1'b0;
            @(negedge clk);
            if (mem_write) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL coal_extra got=%h exp=none", mem_address); end
                else begin
                    if ({mem_address, mem_writedata, mem_byteenable} !== exp_q[0]) begin bad++; $display("FAIL coal_memwr got=%h/%h/%h exp=%h/%h/%h", mem_address, mem_writedata, mem_byteenable, exp_q[0].a, exp_q[0].d, exp_q[0].b); end
                    void'(exp_q.pop_front());
                end
            end
        end
        total++; if (exp_q.size() != 0 || wb_empty !== 1'b1) begin bad++; $display("FAIL coal_drain got=%0d left/empty=%b exp=0/1", exp_q.size(), wb_empty); end
    endtask

    task automatic test_reset_mid_write();
        mem_waitrequest = 1'b1;
        cyc();
        cpu_write = 1'b1; cpu_address = 32'h90; cpu_writedata = $urandom; cpu_byteenable = 4'hF;
        cyc();
        cpu_write = 1'b0;
        cyc();
        @(negedge clk);
        total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", mem_write); end
        #2 reset = 1'b1;
        #1;
        total++; if ({mem_write, wb_empty, cpu_waitrequest} !== 3'b011 || wb_count !== 3'd0) begin bad++; $display("FAIL rstmid_async got=%b/%0d exp=011/0", {mem_write, wb_empty, cpu_waitrequest}, wb_count); end
        cyc();
        reset = 1'b0;
        @(negedge clk);
        total++; if ({mem_write, wb_empty} !== 2'b01 || wb_count !== 3'd0) begin bad++; $display("FAIL rstmid_after got=%b/%0d exp=01/0", {mem_write, wb_empty}, wb_count); end
        for (int c = 0; c < 4; c++) begin
            cyc();
            mem_waitrequest = 1'b0;
            @(negedge clk);
            total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rstmid_discard[%0d] got=%b exp=0", c, mem_write); end
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        bit pend_w, pend_r, rd_got;
        logic [31:0] pa, pd, rd_exp, next_addr;
        logic [3:0] pb;
        int r;
        pend_w = 0; pend_r = 0; rd_got = 0; next_addr = 32'h1000; rd_exp = '0; pa = '0; pd = '0; pb = '0;
        for (int c = 0; c < 700; c++) begin
            cyc();
            if (!pend_w && !pend_r && c < 620) begin
                r = $urandom_range(0, 9);
                if (r < 5) begin
                    pend_w = 1; pa = next_addr; next_addr += 4; pd = $urandom; pb = 4'($urandom_range(1, 15));
                end else if (r == 5) begin
                    pend_r = 1; pa = $urandom & 32'hFFFF_FFFC; pb = 4'($urandom); rd_got = 0;
                end
            end
            cpu_write = pend_w; cpu_read = pend_r; cpu_address = pa; cpu_writedata = pd; cpu_byteenable = pb;
            mem_waitrequest = ($urandom_range(0, 3) == 0);
            mem_readdata = $urandom;
            @(negedge clk);
            total++; if (mem_write && mem_read) begin bad++; $display("FAIL rnd_exclusive[%0d] got=11 exp=not both", c); end
            total++; if (wb_count !== 3'(q.size()) || wb_empty !== (q.size() == 0)) begin bad++; $display("FAIL rnd_count[%0d] got=%0d/%b exp=%0d", c, wb_count, wb_empty, q.size()); end
            if (pend_w) begin
                total++; if (cpu_waitrequest !== (q.size() == DEPTH)) begin bad++; $display("FAIL rnd_wwait[%0d] got=%b exp=%b", c, cpu_waitrequest, (q.size() == DEPTH)); end
            end
            if (mem_write && !mem_waitrequest) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL rnd_extra[%0d] got=%h exp=none", c, mem_address); end
                else begin
                    if ({mem_address, mem_writedata, mem_byteenable} !== q[0]) begin bad++; $display("FAIL rnd_memwr[%0d] got=%h/%h/%h exp=%h/%h/%h", c, mem_address, mem_writedata, mem_byteenable, q[0].a, q[0].d, q[0].b); end
                    void'(q.pop_front());
                end
            end
            if (mem_read) begin
                total++; if (q.size() != 0 || mem_address !== pa || mem_byteenable !== pb) begin bad++; $display("FAIL rnd_memrd[%0d] got=%h/%h pend=%0d exp=%h/%h pend=0", c, mem_address, mem_byteenable, q.size(), pa, pb); end
                if (!mem_waitrequest) begin rd_exp = mem_readdata; rd_got = 1; end
            end
            if (pend_r && !cpu_waitrequest) begin
                total++; if (!rd_got || cpu_readdata !== rd_exp) begin bad++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", c, cpu_readdata, rd_exp); end
                pend_r = 0;
            end
            if (pend_w && !cpu_waitrequest) begin
                q.push_back('{a: pa, d: pd, b: pb});
                pend_w = 0;
            end
        end
        total++; if (pend_w || pend_r || q.size() != 0) begin bad++; $display("FAIL rnd_final got=w%0d r%0d q%0d exp=0 0 0", pend_w, pend_r, q.size()); end
        cpu_write = 1'b0; cpu_read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_order();
        test_read_after_write();
        test_read_latency();
        test_coalesce();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_write_buffer.md
MIPS_WRITE_BUFFER -- requirements
Module: mips_write_buffer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; multiple of 8. BE_W = DATA_W/8.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, asynchronous active-high reset.
- cpu_address, in, ADDR_W, CPU-side word address.
- cpu_write, in, 1, CPU write request.
- cpu_read, in, 1, CPU read request.
- cpu_writedata, in, DATA_W, write data.
- cpu_byteenable, in, BE_W, write/read lane enables.
- cpu_waitrequest, out, 1, stall to CPU side.
- cpu_readdata, out, DATA_W, read data.
- mem_address, out, ADDR_W, Avalon master address.
- mem_write, out, 1, Avalon write.
- mem_read, out, 1, Avalon read.
- mem_writedata, out, DATA_W, Avalon write data.
- mem_byteenable, out, BE_W, Avalon byte enables.
- mem_waitrequest, in, 1, Avalon stall.
- mem_readdata, in, DATA_W, Avalon read data.
- wb_empty, out, 1, buffer holds no entries and no write is in flight.
- wb_count, out, $clog2(DEPTH)+1, occupied entries.

Function
REQ-003 CPU side SHALL be Avalon-slave style: the request is held until a cycle with cpu_waitrequest=0, and completes in that cycle.
REQ-004 A cpu_write with wb_count<DEPTH at cycle start SHALL complete in the same cycle (cpu_waitrequest=0) and enqueue {address, data, byteenable} at the clock edge.
REQ-005 A cpu_write while full SHALL see cpu_waitrequest=1; no same-cycle bypass when a dequeue coincides, so acceptance occurs the cycle after space frees.
REQ-006 The drain FSM SHALL have states IDLE, WR_ISSUE, RD_ISSUE and RD_DONE.
REQ-007 IDLE -> WR_ISSUE when non-empty: head entry driven on mem_*, mem_write=1. The write is held stable until mem_waitrequest=0; the head is then popped and the FSM goes to WR_ISSUE again if more entries remain, else IDLE.
REQ-008 A cpu_read SHALL stall until the buffer is empty and the FSM is in IDLE. The FSM then goes to RD_ISSUE: mem_read=1, mem_address=cpu_address, mem_byteenable=cpu_byteenable.
REQ-009 In RD_ISSUE, when mem_waitrequest=0, mem_readdata SHALL be registered and the FSM goes to RD_DONE. In RD_DONE, cpu_waitrequest=0 and cpu_readdata=registered data, followed by IDLE. Minimum read latency is 2 cycles from an empty buffer.
REQ-010 Pending writes SHALL drain before a read; memory order equals CPU order.
REQ-011 mem_write and mem_read SHALL never be high together.
REQ-012 cpu_write and cpu_read both high is illegal; the block SHALL treat it as write-only.
REQ-013 Pointers SHALL wrap modulo DEPTH. wb_count SHALL be unchanged when an enqueue and a pop occur in the same cycle.
REQ-014 wb_empty SHALL be 1 only if wb_count=0 and the FSM is not in WR_ISSUE.

Reset
REQ-015 Asserting reset at any time SHALL immediately force: FSM=IDLE, pointers=0, wb_count=0, wb_empty=1, mem_write=0, mem_read=0, mem_address=0, mem_writedata=0, mem_byteenable=0, cpu_readdata=0.
REQ-016 Buffered and in-flight transactions SHALL be discarded on reset without completion.
REQ-017 cpu_waitrequest SHALL be 1 while reset is high.

Configuration
REQ-018 Macro MIPS_WB_COALESCE_EN, when defined, SHALL merge an accepted cpu_write into the newest entry if:
- the addresses match, and
- that entry is not the head currently in WR_ISSUE.
Enabled lanes are overwritten, mask = old OR new, and wb_count is unchanged. This applies even when the buffer is full.
REQ-019 Without MIPS_WB_COALESCE_EN, every accepted write SHALL occupy its own entry.

Verification
REQ-020 Reset mid-WR_ISSUE with mem_waitrequest=1 -> next cycle mem_write=0, wb_count=0, wb_empty=1.
REQ-021 DEPTH=4, five back-to-back writes to 0x10, 0x14, 0x18, 0x1C, 0x20 with mem_waitrequest=1 -> writes 1-4 accepted; write 5 waitrequest=1 until the first pop; mem addresses appear in order 0x10 to 0x20.
REQ-022 Write 0x40=0xAABBCCDD, then read 0x40 -> read stalls until the write completes; mem_read issued after mem_write; cpu_readdata=mem_readdata in RD_DONE.
REQ-023 Empty buffer, read with mem_waitrequest=0 -> cpu_waitrequest low exactly 2 cycles after cpu_read rises.
REQ-024 COALESCE_EN: head busy (mem_waitrequest=1), writes 0x80 be=0011 data 0x00001122 then 0x80 be=1100 data 0x33440000 -> one entry be=1111 data 0x33441122, wb_count=2. Without the macro -> wb_count=3.
